// File: rtl/fifo_pkg.sv
// Shared FIFO definitions for the AXI-side and UART-side byte buffers.
// Holds the default word/depth sizes and the pointer/level width rule so every
// FIFO instance in the slice agrees on how wide its counters are.
package fifo_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;

  // Pointer width: indexes DEPTH entries (DEPTH is a power of two).
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Level width: one extra bit so a completely full FIFO (level == DEPTH) fits.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the FIFO: DEPTH words of WIDTH bits.
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe, i_wr_data stored at i_wr_addr on the rising edge
//   i_wr_addr  write index
//   i_wr_data  write word
//   i_rd_addr  read index
//   o_rd_data  word at i_rd_addr (asynchronous read)
// Contents are deliberately not reset; the owner tracks which entries are live.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW = addr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_pkt.sv
// Synchronous FIFO of WIDTH-bit words, each tagged with a packet-end flag.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_en, din, din_last     push request with word and packet-end flag
//   rd_en                    pop request (FWFT: acknowledge of the shown word)
//   err_clr                  clears the sticky overflow/underflow flags
//   dout, dout_last          read word and its packet-end flag
//   dout_valid               dout/dout_last carry a word
//   full, empty              occupancy flags
//   almost_full/empty        level >= AF_THRESH / level <= AE_THRESH
//   level                    stored entries, 0..DEPTH
//   pkt_count, pkt_avail     stored entries with last=1, and pkt_count != 0
//   overflow, underflow      sticky rejected-request flags
// FWFT=0: an accepted read registers the head word; dout_valid pulses for one cycle.
// FWFT=1: the head word is shown straight from storage while the FIFO is not empty.
module sync_fifo_pkt
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned DEPTH     = DefDepth,
  parameter bit          FWFT      = 1'b0,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned AW = addr_w(DEPTH),
  localparam int unsigned LW = level_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_last,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_last,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    pkt_count,
  output logic             pkt_avail,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [LW-1:0] DepthL = LW'(DEPTH);
  localparam logic [LW-1:0] AfL    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AeL    = LW'(AE_THRESH);

  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level, r_pkt;
  logic          r_full, r_empty, r_af, r_ae, r_pkt_avail, r_ovf, r_unf;

  logic          w_wr_acc, w_rd_acc, w_head_last;
  logic [WIDTH:0] w_head;
  logic [LW-1:0] w_level_d, w_pkt_d;

  // Acceptance uses this cycle's flags only: a read never frees room for a
  // same-cycle write, and a write never feeds a same-cycle read.
  assign w_wr_acc    = wr_en && !r_full;
  assign w_rd_acc    = rd_en && !r_empty;
  assign w_head_last = w_head[WIDTH];

  fifo_regfile #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_regfile (
    .i_clk     (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr),
    .i_wr_data ({din_last, din}),
    .i_rd_addr (r_rptr),
    .o_rd_data (w_head)
  );

  always_comb begin
    w_level_d = r_level + LW'(w_wr_acc) - LW'(w_rd_acc);
    w_pkt_d   = r_pkt + LW'(w_wr_acc && din_last) - LW'(w_rd_acc && w_head_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_pkt       <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
      r_pkt_avail <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      r_level     <= w_level_d;
      r_pkt       <= w_pkt_d;
      r_full      <= (w_level_d == DepthL);
      r_empty     <= (w_level_d == '0);
      r_af        <= (w_level_d >= AfL);
      r_ae        <= (w_level_d <= AeL);
      r_pkt_avail <= (w_pkt_d != '0);
      // A new error in the clearing cycle must not be lost, so set wins.
      r_ovf       <= (wr_en && r_full) || (r_ovf && !err_clr);
      r_unf       <= (rd_en && r_empty) || (r_unf && !err_clr);
    end
  end

  if (FWFT) begin : g_fwft
    // Masked while empty so stale storage never shows on dout.
    assign dout       = r_empty ? '0 : w_head[WIDTH-1:0];
    assign dout_last  = !r_empty && w_head_last;
    assign dout_valid = !r_empty;
  end else begin : g_std
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_last, r_dout_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dout       <= '0;
        r_dout_last  <= 1'b0;
        r_dout_valid <= 1'b0;
      end else begin
        r_dout_valid <= w_rd_acc;
        if (w_rd_acc) begin
          r_dout      <= w_head[WIDTH-1:0];
          r_dout_last <= w_head_last;
        end
      end
    end

    assign dout       = r_dout;
    assign dout_last  = r_dout_last;
    assign dout_valid = r_dout_valid;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign level        = r_level;
  assign pkt_count    = r_pkt;
  assign pkt_avail    = r_pkt_avail;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_pkt.sv
// Bench for sync_fifo_pkt: a standard-mode and a FWFT instance (DEPTH=4, AF=3,
// AE=1) share one stimulus stream and are compared against a queue model.
module tb_sync_fifo_pkt;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned LW = 3;
  localparam int unsigned AF = 3;
  localparam int unsigned AE = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0, rd_en = 1'b0, din_last = 1'b0, err_clr = 1'b0;
  logic [W-1:0] din = '0;

  logic [W-1:0]  s_dout, f_dout;
  logic          s_last, s_valid, s_full, s_empty, s_af, s_ae, s_avail, s_ovf, s_unf;
  logic          f_last, f_valid, f_full, f_empty, f_af, f_ae, f_avail, f_ovf, f_unf;
  logic [LW-1:0] s_level, s_pkt, f_level, f_pkt;

  always #5 clk = ~clk;

  sync_fifo_pkt #(
    .WIDTH(W), .DEPTH(D), .FWFT(1'b0), .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .din_last(din_last),
    .rd_en(rd_en), .err_clr(err_clr), .dout(s_dout), .dout_last(s_last),
    .dout_valid(s_valid), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .level(s_level), .pkt_count(s_pkt), .pkt_avail(s_avail),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_pkt #(
    .WIDTH(W), .DEPTH(D), .FWFT(1'b1), .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .din_last(din_last),
    .rd_en(rd_en), .err_clr(err_clr), .dout(f_dout), .dout_last(f_last),
    .dout_valid(f_valid), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .level(f_level), .pkt_count(f_pkt), .pkt_avail(f_avail),
    .overflow(f_ovf), .underflow(f_unf)
  );

  // Reference model: queue of {last, data}, sticky errors, standard-mode output.
  logic [W:0]   q[$];
  logic         m_ovf, m_unf, m_last, m_valid;
  logic [W-1:0] m_dout;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pkts_in_q();
    int n = 0;
    foreach (q[i]) if (q[i][W]) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    m_dout = '0; m_last = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    int  lvl;
    bit  is_full, is_empty, wa, ra;
    lvl      = q.size();
    is_full  = (lvl == D);
    is_empty = (lvl == 0);
    wa       = wr_en && !is_full;
    ra       = rd_en && !is_empty;
    if (wr_en && is_full) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
    if (rd_en && is_empty) m_unf = 1'b1; else if (err_clr) m_unf = 1'b0;
    m_valid = ra;
    if (ra) begin
      m_dout = q[0][W-1:0];
      m_last = q[0][W];
      void'(q.pop_front());
    end
    if (wa) q.push_back({din_last, din});
  endtask

  task automatic check_all();
    int         lvl, pk;
    logic [W:0] head;
    lvl  = q.size();
    pk   = pkts_in_q();
    head = (lvl != 0) ? q[0] : '0;
    check("std.level", 32'(s_level), lvl);
    check("std.pkt_count", 32'(s_pkt), pk);
    check("std.pkt_avail", 32'(s_avail), 32'(pk != 0));
    check("std.full", 32'(s_full), 32'(lvl == D));
    check("std.empty", 32'(s_empty), 32'(lvl == 0));
    check("std.almost_full", 32'(s_af), 32'(lvl >= AF));
    check("std.almost_empty", 32'(s_ae), 32'(lvl <= AE));
    check("std.overflow", 32'(s_ovf), 32'(m_ovf));
    check("std.underflow", 32'(s_unf), 32'(m_unf));
    check("std.dout", 32'(s_dout), 32'(m_dout));
    check("std.dout_last", 32'(s_last), 32'(m_last));
    check("std.dout_valid", 32'(s_valid), 32'(m_valid));
    check("fwft.level", 32'(f_level), lvl);
    check("fwft.pkt_count", 32'(f_pkt), pk);
    check("fwft.full", 32'(f_full), 32'(lvl == D));
    check("fwft.empty", 32'(f_empty), 32'(lvl == 0));
    check("fwft.overflow", 32'(f_ovf), 32'(m_ovf));
    check("fwft.underflow", 32'(f_unf), 32'(m_unf));
    check("fwft.dout", 32'(f_dout), 32'(head[W-1:0]));
    check("fwft.dout_last", 32'(f_last), 32'(head[W]));
    check("fwft.dout_valid", 32'(f_valid), 32'(lvl != 0));
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 1 time unit later.
  task automatic drive(input bit w, input logic [W-1:0] d, input bit l, input bit r,
                       input bit c);
    wr_en = w; din = d; din_last = l; rd_en = r; err_clr = c;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din_last = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must react without a clock.
  task automatic do_reset();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din_last = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [W-1:0] exp_rd [4];

  initial begin
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;
    model_reset();
    #1 rst = 1'b1;
    #1 check_all();
    #6 rst = 1'b0;

    // Fill to full, last flag on the fourth word; fifth write overflows.
    drive(1, 8'h11, 0, 0, 0);
    drive(1, 8'h22, 0, 0, 0);
    drive(1, 8'h33, 0, 0, 0);
    drive(1, 8'h44, 1, 0, 0);
    check("tp.full", 32'(s_full), 1);
    check("tp.level4", 32'(s_level), 4);
    check("tp.pkt1", 32'(s_pkt), 1);
    drive(1, 8'hEE, 0, 0, 0);
    check("tp.overflow", 32'(s_ovf), 1);

    // Drain: each word appears one cycle after its read request.
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 0, 1, 0);
      check("tp.rd_data", 32'(s_dout), 32'(exp_rd[i]));
      check("tp.rd_last", 32'(s_last), 32'(i == 3));
    end
    drive(0, '0, 0, 0, 0);
    check("tp.last_held", 32'(s_last), 1);
    check("tp.valid_pulse", 32'(s_valid), 0);
    drive(0, '0, 0, 1, 0);
    check("tp.underflow", 32'(s_unf), 1);
    drive(0, '0, 0, 0, 1);
    check("tp.err_clr", 32'(s_ovf), 0);

    // Simultaneous write+read at level 2, at full and at empty.
    drive(1, 8'h01, 0, 0, 0);
    drive(1, 8'h02, 1, 0, 0);
    drive(1, 8'h03, 0, 1, 0);
    check("tp.wr_rd_lvl2", 32'(s_level), 2);
    drive(1, 8'h04, 0, 0, 0);
    drive(1, 8'h05, 1, 0, 0);
    drive(1, 8'h06, 0, 1, 0);
    check("tp.wr_rd_full", 32'(s_level), 3);
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 1, 0);
    drive(1, 8'h07, 0, 1, 0);
    check("tp.wr_rd_empty", 32'(s_level), 1);
    drive(0, '0, 0, 1, 0);

    // Clear racing a new overflow: the new error wins.
    drive(0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 8'(8'h80 + i), 0, 0, 0);
    drive(1, 8'hFF, 0, 0, 1);
    check("tp.ovf_set_wins", 32'(s_ovf), 1);
    for (int i = 0; i < 4; i++) drive(0, '0, 0, 1, 0);

    // Pointer wrap through ten write/read pairs.
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(8'h60 + i), 1'(i % 3 == 0), 0, 0);
      drive(0, '0, 0, 1, 0);
      check("tp.wrap_data", 32'(s_dout), 32'(8'h60 + i));
    end

    // FWFT: word visible the cycle after writing into an empty FIFO.
    drive(1, 8'hA5, 0, 0, 0);
    check("tp.fwft_dout", 32'(f_dout), 32'h0A5);
    check("tp.fwft_valid", 32'(f_valid), 1);
    drive(0, '0, 0, 1, 0);
    check("tp.fwft_empty", 32'(f_empty), 1);

    // Randomised traffic with a reset dropped in mid-burst.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      drive(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
